// File: rtl/rv32i_pkg.sv
// Shared types and defaults for the RV32I instruction-fetch stage.
package rv32i_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam int          FIFO_DEPTH_DEFAULT = 2;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_FLUSH
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {instr, pc} entries with single-cycle flush.
module fetch_fifo
  import rv32i_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // NOTE: storage is deliberately not reset; count alone decides which entries
  // are meaningful, so the array stays plain reset-free flops or RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The fetch credit rule keeps outstanding + buffered <= DEPTH.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !flush));

endmodule

// File: rtl/rv32i_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited in-order imem requests,
// buffers responses and squashes stale ones after a branch redirect.
module rv32i_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rstB,
  input  logic        jmp_occur,
  input  logic [31:0] pc_jmpto,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_current,
  input  logic        instr_ready
);

  localparam int             CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

  fetch_state_e     state;
  logic             jmp_q;
  logic [31:0]      fetch_pc;
  logic [31:0]      resp_pc;
  logic [31:0]      target;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_next;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] discard_next;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credit_used;
  logic             redirect;
  logic             gnt_fire;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  fetch_entry_t     head;

  // Only the first cycle of a held jmp_occur redirects; boot ignores it.
  assign redirect    = jmp_occur && !jmp_q && (state != S_BOOT);
  assign target      = word_align(pc_jmpto);
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};

  // Outstanding requests still awaiting discard count against credit too.
  assign imem_req  = (state != S_BOOT) && !redirect && (credit_used < CREDIT_MAX);
  assign imem_addr = fetch_pc;
  assign gnt_fire  = imem_req && imem_gnt;
  assign push      = imem_rvalid && (discard == '0) && !redirect;
  assign pop       = instr_valid && instr_ready && !redirect;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    outstanding_next = outstanding;
    if (gnt_fire && !imem_rvalid)      outstanding_next = outstanding + CNT_W'(1);
    else if (!gnt_fire && imem_rvalid) outstanding_next = outstanding - CNT_W'(1);

    discard_next = discard;
    if (redirect)                             discard_next = outstanding_next;
    else if (imem_rvalid && discard != '0)    discard_next = discard - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstB) begin
      state       <= S_BOOT;
      jmp_q       <= 1'b0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      jmp_q       <= jmp_occur;
      outstanding <= outstanding_next;
      discard     <= discard_next;

      if (redirect)      fetch_pc <= target;
      else if (gnt_fire) fetch_pc <= fetch_pc + 32'd4;

      if (redirect)  resp_pc <= target;
      else if (push) resp_pc <= resp_pc + 32'd4;

      unique case (state)
        S_BOOT:  state <= S_RUN;
        S_RUN:   if (redirect && outstanding_next != '0) state <= S_FLUSH;
        S_FLUSH: if (discard_next == '0) state <= S_RUN;
        default: state <= S_BOOT;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rstB),
    .flush     (redirect),
    .push      (push),
    .push_data ('{instr: imem_rdata, pc: resp_pc}),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = instr_valid ? head.instr : '0;
  assign pc_current  = instr_valid ? head.pc : RESET_PC;

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Self-checking bench for rv32i_fetch_unit: behavioural memory plus an
// instruction-stream reference model checked every cycle.
module tb_rv32i_fetch_unit;
  import rv32i_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rstB;
  logic        jmp_occur;
  logic [31:0] pc_jmpto;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_current;
  logic        instr_ready;

  rv32i_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rstB        (rstB),
    .jmp_occur   (jmp_occur),
    .pc_jmpto    (pc_jmpto),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc_current  (pc_current),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } resp_t;

  resp_t       memq[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          epoch, live, buffered, grants, last_due, since_reset, first_valid_c;
  bit          in_boot, prev_jmp;
  logic [31:0] exp_req_pc, exp_pop_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic int stale_out();
    int n = 0;
    foreach (memq[i]) if (memq[i].epoch != epoch) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // One clock of stimulus: drive at negedge, check and advance the model 1 unit later.
  task automatic step(input bit jmp, input logic [31:0] tgt, input bit rdy,
                      input int gnt_pct, input int lat_min, input int lat_max);
    bit    redirect_m, exp_valid, exp_req;
    resp_t r;
    @(negedge clk);
    rstB        = 1'b1;
    jmp_occur   = jmp;
    pc_jmpto    = tgt;
    instr_ready = rdy;
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    imem_rvalid = 1'b0;
    if (memq.size() > 0) imem_rvalid = (memq[0].due <= cyc);
    imem_rdata  = imem_rvalid ? mem_word(memq[0].addr) : $urandom;
    #1;
    exp_valid = (buffered > 0);
    check("instr_valid", 32'(instr_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("pc_current", pc_current, exp_pop_pc);
      check("instr", instr, mem_word(exp_pop_pc));
    end
    redirect_m = jmp && !prev_jmp && !in_boot;
    if (redirect_m) begin
      epoch++;
      exp_req_pc = tgt & ~32'd3;
      exp_pop_pc = exp_req_pc;
      live       = 0;
      buffered   = 0;
    end
    exp_req = !in_boot && !redirect_m && (stale_out() + live < DEPTH);
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, exp_req_pc);
    if (!redirect_m && exp_valid && rdy) begin
      buffered--;
      live--;
      exp_pop_pc += 32'd4;
    end
    if (exp_req && imem_gnt) begin
      r.addr  = exp_req_pc;
      r.due   = cyc + $urandom_range(lat_max, lat_min);
      r.epoch = epoch;
      if (r.due < last_due) r.due = last_due;
      last_due = r.due;
      memq.push_back(r);
      exp_req_pc += 32'd4;
      live++;
      grants++;
    end
    if (imem_rvalid) begin
      r = memq.pop_front();
      if (r.epoch == epoch) buffered++;
    end
    if (instr_valid && first_valid_c < 0) first_valid_c = since_reset;
    prev_jmp = jmp;
    in_boot  = 1'b0;
    since_reset++;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rstB        = 1'b0;
      jmp_occur   = 1'b0;
      instr_ready = 1'($urandom_range(1));
      imem_gnt    = 1'b1;
      imem_rvalid = (memq.size() > 0);
      imem_rdata  = $urandom;
      #1;
      if (i > 0) begin
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", pc_current, 32'h0);
      end
      cyc++;
    end
    memq.delete();
    epoch = 0; live = 0; buffered = 0; last_due = 0;
    since_reset = 0; first_valid_c = -1;
    exp_req_pc = 32'h0; exp_pop_pc = 32'h0;
    in_boot = 1'b1; prev_jmp = 1'b0;
  endtask

  // Let every live and stale request complete, with a cycle budget.
  task automatic drain();
    for (int i = 0; i < 20 && (live > 0 || memq.size() > 0); i++) step(0, 0, 1, 0, 1, 1);
    check("drain_done", 32'(live + memq.size()), 32'd0);
  endtask

  initial begin
    int g0;
    rstB = 1'b0; jmp_occur = 1'b0; pc_jmpto = '0; instr_ready = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; grants = 0;
    do_reset(3);

    // Streaming with 1-cycle memory latency.
    repeat (12) step(0, 0, 1, 100, 1, 1);
    check("first_valid_cycle", 32'(first_valid_c), 32'd3);

    // Backpressure: exactly DEPTH grants, then resume without loss.
    drain();
    g0 = grants;
    repeat (8) step(0, 0, 0, 100, 1, 1);
    check("bp_grants", 32'(grants - g0), 32'd2);
    repeat (10) step(0, 0, 1, 100, 1, 1);

    // Redirect to 0x100 with two long-latency requests in flight.
    drain();
    repeat (2) step(0, 0, 1, 100, 4, 4);
    check("inflight_before_jmp", 32'(memq.size()), 32'd2);
    step(1, 32'h100, 1, 100, 1, 1);
    step(1, 32'h0000_0800, 1, 100, 1, 1);
    repeat (12) step(0, 0, 1, 100, 1, 1);

    // Redirect in the same cycle as a response and an asserted grant.
    for (int i = 0; i < 10 && memq.size() == 0; i++) step(0, 0, 1, 100, 1, 1);
    step(1, 32'h200, 1, 100, 1, 1);
    step(1, 32'h0000_0900, 1, 100, 1, 1);
    repeat (10) step(0, 0, 1, 100, 1, 2);

    // Misaligned target, then wrap past the top of the address space.
    step(1, 32'h103, 1, 100, 1, 1);
    step(1, 32'h0000_0a00, 1, 100, 1, 1);
    repeat (8) step(0, 0, 1, 100, 1, 1);
    step(1, 32'hFFFF_FFF8, 1, 100, 1, 1);
    step(1, 32'h0, 1, 100, 1, 1);
    repeat (10) step(0, 0, 1, 100, 1, 1);

    // Randomised traffic with two-cycle jumps.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(15) == 0) begin
        step(1, $urandom, 1'($urandom_range(1)), 70, 1, 3);
        step(1, $urandom, 1'($urandom_range(1)), 70, 1, 3);
      end
      step(0, 0, 1'($urandom_range(1)), 70, 1, 3);
    end

    // Reset mid-stream with responses pending.
    for (int i = 0; i < 10 && memq.size() == 0; i++) step(0, 0, 1, 100, 3, 3);
    do_reset(3);
    repeat (10) step(0, 0, 1, 100, 1, 1);
    check("refetch_first_valid", 32'(first_valid_c), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
